// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - opcode constants, controller states and output-select codes for imem_loadable_predecode
package imem_pkg;

    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_BNE   = 6'b000101;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [5:0]  OP_JAL   = 6'b000011;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } imem_state_e;

    typedef enum logic [1:0] {
        OUT_HOLD  = 2'd0,
        OUT_CLEAR = 2'd1,
        OUT_FAULT = 2'd2,
        OUT_FETCH = 2'd3
    } out_sel_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/imem_loadable_predecode_if.sv
// rtl/imem_loadable_predecode_if.sv - load port and fetch port bundle; IMEM_JUMP_PREDECODE_EN adds jump outputs
interface imem_loadable_predecode_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 512
);
    localparam int CNT_W = $clog2(MEM_DEPTH) + 1;

    logic                  i_load_valid;
    logic [DATA_WIDTH-1:0] i_load_data;
    logic                  i_load_last;
    logic                  i_reload;
    logic [ADDR_WIDTH-1:0] i_pc;
    logic                  i_stall;
    logic                  i_flush;
    logic [DATA_WIDTH-1:0] o_instr;
    logic                  o_valid;
    logic                  o_branch;
    logic [31:0]           o_target_offset;
    logic                  o_fault;
    logic [1:0]            o_state;
    logic [CNT_W-1:0]      o_load_count;
`ifdef IMEM_JUMP_PREDECODE_EN
    logic                  o_jump;
    logic [31:0]           o_jump_target;

    modport slave (
        input  i_load_valid, i_load_data, i_load_last, i_reload, i_pc, i_stall, i_flush,
        output o_instr, o_valid, o_branch, o_target_offset, o_fault, o_state, o_load_count,
               o_jump, o_jump_target
    );
    modport master (
        output i_load_valid, i_load_data, i_load_last, i_reload, i_pc, i_stall, i_flush,
        input  o_instr, o_valid, o_branch, o_target_offset, o_fault, o_state, o_load_count,
               o_jump, o_jump_target
    );
`else
    modport slave (
        input  i_load_valid, i_load_data, i_load_last, i_reload, i_pc, i_stall, i_flush,
        output o_instr, o_valid, o_branch, o_target_offset, o_fault, o_state, o_load_count
    );
    modport master (
        output i_load_valid, i_load_data, i_load_last, i_reload, i_pc, i_stall, i_flush,
        input  o_instr, o_valid, o_branch, o_target_offset, o_fault, o_state, o_load_count
    );
`endif

endinterface

// File: rtl/imem_predecode.sv
// rtl/imem_predecode.sv - combinational branch/jump predecode of one instruction word (jump part under IMEM_JUMP_PREDECODE_EN)
module imem_predecode
    import imem_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [15:0] imm16_i,
`ifdef IMEM_JUMP_PREDECODE_EN
    input  logic [25:0] index_i,
    input  logic [3:0]  pc_hi_i,
    output logic        jump_o,
    output logic [31:0] jump_target_o,
`endif
    output logic        branch_o,
    output logic [31:0] offset_o
);

    always_comb begin
        branch_o = (opcode_i == OP_BEQ) || (opcode_i == OP_BNE);
        offset_o = branch_o ? sext16(imm16_i) : 32'h0;
    end

`ifdef IMEM_JUMP_PREDECODE_EN
    always_comb begin
        jump_o        = (opcode_i == OP_J) || (opcode_i == OP_JAL);
        jump_target_o = jump_o ? {pc_hi_i, index_i, 2'b00} : 32'h0;
    end
`endif

endmodule

// File: rtl/imem_loadable_predecode.sv
// rtl/imem_loadable_predecode.sv - run-time loadable instruction store with LOAD/RUN/HALT control, stall/flush and predecode; IMEM_JUMP_PREDECODE_EN enables jump predecode
module imem_loadable_predecode
    import imem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 512,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       reset,
    imem_loadable_predecode_if.slave   bus
);

    localparam int               IDX_W    = $clog2(MEM_DEPTH);
    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    imem_state_e           state_q, state_d;
    logic [IDX_W-1:0]      wptr_q, wptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;
    logic                  branch_q, branch_d;
    logic [31:0]           off_q, off_d;
    logic                  fault_q, fault_d;
    out_sel_e              out_sel;

    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  pc_fault;
    logic                  pd_branch;
    logic [31:0]           pd_off;
    logic                  wr_en;

    assign rd_idx   = bus.i_pc[IDX_W+1:2];
    assign rd_word  = mem[rd_idx];
    assign pc_fault = (|bus.i_pc[1:0]) || (|bus.i_pc[ADDR_WIDTH-1:IDX_W+2]);
    assign wr_en    = !reset && !bus.i_reload && (state_q == LOAD) && bus.i_load_valid;

`ifdef IMEM_JUMP_PREDECODE_EN
    logic        jump_q, jump_d, pd_jump;
    logic [31:0] jtgt_q, jtgt_d, pd_jtgt;
    logic [3:0]  pc_hi;

    // Upper nibble of pc+4 forms the jump region.
    assign pc_hi = 4'((32'(bus.i_pc) + 32'd4) >> 28);

    imem_predecode u_predecode (
        .opcode_i      (rd_word[31:26]),
        .imm16_i       (rd_word[15:0]),
        .index_i       (rd_word[25:0]),
        .pc_hi_i       (pc_hi),
        .jump_o        (pd_jump),
        .jump_target_o (pd_jtgt),
        .branch_o      (pd_branch),
        .offset_o      (pd_off)
    );
`else
    imem_predecode u_predecode (
        .opcode_i (rd_word[31:26]),
        .imm16_i  (rd_word[15:0]),
        .branch_o (pd_branch),
        .offset_o (pd_off)
    );
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= bus.i_load_data;
        end
    end

    // Controller: picks the next state and which kind of value the fetch registers take.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        out_sel = OUT_HOLD;
        if (bus.i_reload) begin
            state_d = LOAD;
            wptr_d  = '0;
            cnt_d   = '0;
            out_sel = OUT_CLEAR;
        end else begin
            case (state_q)
                LOAD: begin
                    out_sel = OUT_CLEAR;
                    if (bus.i_load_valid) begin
                        wptr_d = wptr_q + IDX_W'(1);
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (bus.i_load_last || (wptr_q == LAST_IDX)) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.i_flush) begin
                        out_sel = OUT_CLEAR;
                    end else if (bus.i_stall) begin
                        out_sel = OUT_HOLD;
                    end else if (pc_fault) begin
                        out_sel = OUT_FAULT;
                    end else begin
                        out_sel = OUT_FETCH;
                        if (rd_word == HALT_WORD) begin
                            state_d = HALT;
                        end
                    end
                end
                HALT: out_sel = OUT_CLEAR;
                default: begin
                    state_d = LOAD;
                    out_sel = OUT_CLEAR;
                end
            endcase
        end
    end

    always_comb begin
        instr_d  = instr_q;
        valid_d  = valid_q;
        branch_d = branch_q;
        off_d    = off_q;
        fault_d  = fault_q;
`ifdef IMEM_JUMP_PREDECODE_EN
        jump_d   = jump_q;
        jtgt_d   = jtgt_q;
`endif
        case (out_sel)
            OUT_CLEAR, OUT_FAULT: begin
                instr_d  = DATA_WIDTH'(NOP_WORD);
                valid_d  = 1'b0;
                branch_d = 1'b0;
                off_d    = 32'h0;
                fault_d  = (out_sel == OUT_FAULT);
`ifdef IMEM_JUMP_PREDECODE_EN
                jump_d   = 1'b0;
                jtgt_d   = 32'h0;
`endif
            end
            OUT_FETCH: begin
                instr_d  = rd_word;
                valid_d  = 1'b1;
                branch_d = pd_branch;
                off_d    = pd_off;
                fault_d  = 1'b0;
`ifdef IMEM_JUMP_PREDECODE_EN
                jump_d   = pd_jump;
                jtgt_d   = pd_jtgt;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            wptr_q   <= '0;
            cnt_q    <= '0;
            instr_q  <= DATA_WIDTH'(NOP_WORD);
            valid_q  <= 1'b0;
            branch_q <= 1'b0;
            off_q    <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            branch_q <= branch_d;
            off_q    <= off_d;
            fault_q  <= fault_d;
        end
    end

`ifdef IMEM_JUMP_PREDECODE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            jump_q <= 1'b0;
            jtgt_q <= 32'h0;
        end else begin
            jump_q <= jump_d;
            jtgt_q <= jtgt_d;
        end
    end

    assign bus.o_jump        = jump_q;
    assign bus.o_jump_target = jtgt_q;
`endif

    assign bus.o_instr         = instr_q;
    assign bus.o_valid         = valid_q;
    assign bus.o_branch        = branch_q;
    assign bus.o_target_offset = off_q;
    assign bus.o_fault         = fault_q;
    assign bus.o_state         = state_q;
    assign bus.o_load_count    = cnt_q;

endmodule

// File: tb/tb_imem_loadable_predecode.sv
// tb/tb_imem_loadable_predecode.sv - scoreboard bench for imem_loadable_predecode (jump checks under IMEM_JUMP_PREDECODE_EN)
module tb_imem_loadable_predecode;

    typedef struct packed {
        logic [31:0] instr;
        logic        valid;
        logic        branch;
        logic [31:0] off;
        logic        fault;
    } fetch_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    fetch_t sb[$];

    always #5 clk = ~clk;

    imem_loadable_predecode_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(512)) bus ();

    imem_loadable_predecode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic fetch_t observe();
        return '{bus.o_instr, bus.o_valid, bus.o_branch, bus.o_target_offset, bus.o_fault};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [31:0] pc, input logic stall, input logic flush);
        bus.i_pc    = pc;
        bus.i_stall = stall;
        bus.i_flush = flush;
        step();
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        bus.i_load_valid = 1'b1;
        bus.i_load_data  = data;
        bus.i_load_last  = last;
        step();
        bus.i_load_valid = 1'b0;
        bus.i_load_last  = 1'b0;
    endtask

    task automatic do_reload();
        bus.i_reload = 1'b1;
        step();
        bus.i_reload = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++;
        if (bus.o_state !== 2'd0 || bus.o_load_count !== 10'd0 || observe() !== fetch_t'(0)) begin
            bad++;
            $display("FAIL reset state=%0d count=%0d out=%h required state=0 count=0 out=0",
                     bus.o_state, bus.o_load_count, observe());
        end
        reset = 1'b0;
    endtask

    task automatic test_load();
        load_word(32'h0042_9820, 1'b0);
        total++;
        if (bus.o_load_count !== 10'd1 || bus.o_state !== 2'd0 || bus.o_valid !== 1'b0) begin
            bad++;
            $display("FAIL load_first count=%0d state=%0d valid=%b required 1 0 0",
                     bus.o_load_count, bus.o_state, bus.o_valid);
        end
        load_word(32'h8E64_0014, 1'b0);
        load_word(32'hFFFF_FFFF, 1'b1);
        total++;
        if (bus.o_load_count !== 10'd3 || bus.o_state !== 2'd1) begin
            bad++;
            $display("FAIL load_last count=%0d state=%0d required 3 1", bus.o_load_count, bus.o_state);
        end
    endtask

    task automatic test_fetch_halt();
        logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
        sb.push_back('{32'h0042_9820, 1'b1, 1'b0, 32'h0, 1'b0});
        sb.push_back('{32'h8E64_0014, 1'b1, 1'b0, 32'h0, 1'b0});
        sb.push_back('{32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            fetch_t exp;
            cyc(pcs[i], 1'b0, 1'b0);
            exp = sb.pop_front();
            total++;
            if (observe() !== exp) begin
                bad++;
                $display("FAIL fetch pc=%h got=%h required=%h", pcs[i], observe(), exp);
            end
        end
        total++;
        if (bus.o_state !== 2'd2) begin
            bad++;
            $display("FAIL halt_state got=%0d required=2", bus.o_state);
        end
        cyc(32'h0, 1'b0, 1'b0);
        total++;
        if (observe() !== fetch_t'(0) || bus.o_state !== 2'd2) begin
            bad++;
            $display("FAIL halt_nop out=%h state=%0d required out=0 state=2", observe(), bus.o_state);
        end
    endtask

    task automatic test_reload_program();
        logic [31:0] prog [7] = '{32'h2008_0001, 32'h0800_0010, 32'h1492_0003, 32'h0000_0000,
                                  32'h1092_FFFC, 32'h1092_0006, 32'hFFFF_FFFF};
        do_reload();
        total++;
        if (bus.o_state !== 2'd0 || bus.o_load_count !== 10'd0) begin
            bad++;
            $display("FAIL reload_halt state=%0d count=%0d required 0 0", bus.o_state, bus.o_load_count);
        end
        for (int i = 0; i < 7; i++) load_word(prog[i], i == 6);
        total++;
        if (bus.o_state !== 2'd1 || bus.o_load_count !== 10'd7) begin
            bad++;
            $display("FAIL load_prog state=%0d count=%0d required 1 7", bus.o_state, bus.o_load_count);
        end
    endtask

    task automatic test_branch();
        logic [31:0] pcs [5] = '{32'h10, 32'h14, 32'h08, 32'h04, 32'h00};
        sb.push_back('{32'h1092_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0});
        sb.push_back('{32'h1092_0006, 1'b1, 1'b1, 32'h0000_0006, 1'b0});
        sb.push_back('{32'h1492_0003, 1'b1, 1'b1, 32'h0000_0003, 1'b0});
        sb.push_back('{32'h0800_0010, 1'b1, 1'b0, 32'h0, 1'b0});
        sb.push_back('{32'h2008_0001, 1'b1, 1'b0, 32'h0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            fetch_t exp;
            cyc(pcs[i], 1'b0, 1'b0);
            exp = sb.pop_front();
            total++;
            if (observe() !== exp) begin
                bad++;
                $display("FAIL branch pc=%h got=%h required=%h", pcs[i], observe(), exp);
            end
`ifdef IMEM_JUMP_PREDECODE_EN
            total++;
            if (bus.o_jump !== (pcs[i] == 32'h4) ||
                bus.o_jump_target !== ((pcs[i] == 32'h4) ? 32'h0000_0040 : 32'h0)) begin
                bad++;
                $display("FAIL jump pc=%h got=%b/%h", pcs[i], bus.o_jump, bus.o_jump_target);
            end
`endif
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] pcs   [6] = '{32'h10, 32'h14, 32'h00, 32'h02, 32'h14, 32'h14};
        logic        stall [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        flush [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        fetch_t held = '{32'h1092_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0};
        for (int i = 0; i < 4; i++) sb.push_back(held);
        sb.push_back(fetch_t'(0));
        sb.push_back('{32'h1092_0006, 1'b1, 1'b1, 32'h0000_0006, 1'b0});
        for (int i = 0; i < 6; i++) begin
            fetch_t exp;
            cyc(pcs[i], stall[i], flush[i]);
            exp = sb.pop_front();
            total++;
            if (observe() !== exp) begin
                bad++;
                $display("FAIL stall_flush idx=%0d got=%h required=%h", i, observe(), exp);
            end
        end
    endtask

    task automatic test_fault();
        logic [31:0] pcs [4] = '{32'h802, 32'h2, 32'h800, 32'h0};
        sb.push_back('{32'h0, 1'b0, 1'b0, 32'h0, 1'b1});
        sb.push_back('{32'h0, 1'b0, 1'b0, 32'h0, 1'b1});
        sb.push_back('{32'h0, 1'b0, 1'b0, 32'h0, 1'b1});
        sb.push_back('{32'h2008_0001, 1'b1, 1'b0, 32'h0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            fetch_t exp;
            cyc(pcs[i], 1'b0, 1'b0);
            exp = sb.pop_front();
            total++;
            if (observe() !== exp) begin
                bad++;
                $display("FAIL fault pc=%h got=%h required=%h", pcs[i], observe(), exp);
            end
        end
    endtask

    task automatic test_halt_gating();
        // flush suppresses HALT, stall defers it until released
        cyc(32'h18, 1'b0, 1'b1);
        total++;
        if (observe() !== fetch_t'(0) || bus.o_state !== 2'd1) begin
            bad++;
            $display("FAIL flush_halt out=%h state=%0d required out=0 state=1", observe(), bus.o_state);
        end
        cyc(32'h14, 1'b0, 1'b0);
        cyc(32'h18, 1'b1, 1'b0);
        total++;
        if (bus.o_instr !== 32'h1092_0006 || bus.o_state !== 2'd1) begin
            bad++;
            $display("FAIL stall_halt instr=%h state=%0d required 10920006 1", bus.o_instr, bus.o_state);
        end
        cyc(32'h18, 1'b0, 1'b0);
        total++;
        if (bus.o_instr !== 32'hFFFF_FFFF || bus.o_valid !== 1'b1 || bus.o_state !== 2'd2) begin
            bad++;
            $display("FAIL release_halt instr=%h valid=%b state=%0d required ffffffff 1 2",
                     bus.o_instr, bus.o_valid, bus.o_state);
        end
    endtask

    task automatic test_autofill();
        do_reload();
        for (int i = 0; i < 511; i++) load_word(32'hA500_0000 | i, 1'b0);
        total++;
        if (bus.o_state !== 2'd0 || bus.o_load_count !== 10'd511) begin
            bad++;
            $display("FAIL fill_511 state=%0d count=%0d required 0 511", bus.o_state, bus.o_load_count);
        end
        load_word(32'hA500_01FF, 1'b0);
        total++;
        if (bus.o_state !== 2'd1 || bus.o_load_count !== 10'd512) begin
            bad++;
            $display("FAIL fill_512 state=%0d count=%0d required 1 512", bus.o_state, bus.o_load_count);
        end
        load_word(32'h1234_5678, 1'b1);
        total++;
        if (bus.o_load_count !== 10'd512) begin
            bad++;
            $display("FAIL run_load_ignored count=%0d required 512", bus.o_load_count);
        end
        sb.push_back('{32'hA500_01FF, 1'b1, 1'b0, 32'h0, 1'b0});
        sb.push_back('{32'hA500_0000, 1'b1, 1'b0, 32'h0, 1'b0});
        for (int i = 0; i < 2; i++) begin
            fetch_t exp;
            logic [31:0] pc;
            pc = (i == 0) ? 32'h7FC : 32'h0;
            cyc(pc, 1'b0, 1'b0);
            exp = sb.pop_front();
            total++;
            if (observe() !== exp) begin
                bad++;
                $display("FAIL fill_fetch pc=%h got=%h required=%h", pc, observe(), exp);
            end
        end
        do_reload();
        total++;
        if (bus.o_state !== 2'd0 || bus.o_load_count !== 10'd0 || bus.o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reload_run state=%0d count=%0d valid=%b required 0 0 0",
                     bus.o_state, bus.o_load_count, bus.o_valid);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.i_load_valid = 1'b0;
        bus.i_load_data  = 32'h0;
        bus.i_load_last  = 1'b0;
        bus.i_reload     = 1'b0;
        bus.i_pc         = 32'h0;
        bus.i_stall      = 1'b0;
        bus.i_flush      = 1'b0;
        test_reset();
        test_load();
        test_fetch_halt();
        test_reload_program();
        test_branch();
        test_stall_flush();
        test_fault();
        test_halt_gating();
        test_autofill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loadable_predecode.md
# imem_loadable_predecode

Parametrised successor of the instruction memory: synchronous-read instruction store that is loaded at run time through a word-serial load port, fetched by the IF stage with one-cycle latency, and predecodes branches. It sits between the debug/load unit and the IF/ID pipeline register, adding stall hold, flush-to-NOP, halt detection and a LOAD/RUN/HALT controller.

## Interface
- DATA_WIDTH, 32, instruction word width
- MEM_DEPTH, 512, number of words (power of two)
- ADDR_WIDTH, 32, byte-address width of i_pc
- HALT_WORD, 32'hFFFF_FFFF, instruction value that stops fetch
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- i_load_valid  in  1  load word present on i_load_data
- i_load_data  in  DATA_WIDTH  program word
- i_load_last  in  1  marks final program word
- i_reload  in  1  return to LOAD, clear write pointer
- i_pc  in  ADDR_WIDTH  byte address of fetch
- i_stall  in  1  hold all fetch outputs
- i_flush  in  1  replace next fetch output with NOP
- o_instr  out  DATA_WIDTH  fetched instruction
- o_valid  out  1  o_instr is a real fetch
- o_branch  out  1  o_instr is BEQ (000100) or BNE (000101)
- o_target_offset  out  32  sign-extended imm[15:0] when o_branch, else 0
- o_fault  out  1  i_pc out of range or misaligned
- o_state  out  2  LOAD=0, RUN=1, HALT=2
- o_load_count  out  $clog2(MEM_DEPTH)+1  words written since last LOAD entry

## Operation
- Reset: state LOAD, write pointer 0, o_load_count 0, o_instr 0, o_valid 0, o_branch 0, o_target_offset 0, o_fault 0. Memory contents not cleared.
- LOAD: each cycle with i_load_valid, mem[wptr] <= i_load_data, wptr++. Transition to RUN after the word flagged i_load_last or after word MEM_DEPTH-1 is written; further load words in RUN/HALT ignored. Fetch outputs stay at NOP/o_valid 0.
- RUN: when not stalled, register mem[i_pc[$clog2(MEM_DEPTH)+1:2]] into o_instr, o_valid 1, predecode fields registered in the same edge. i_pc[1:0]≠0 or i_pc ≥ 4*MEM_DEPTH: o_instr 0, o_valid 0, o_fault 1.
- Fetched word equal to HALT_WORD: presented once with o_valid 1, then state HALT; in HALT outputs NOP, o_valid 0, o_fault 0.
- i_reload (any state): next state LOAD, wptr and o_load_count cleared, outputs NOP.
- Priority per edge: reset > i_reload > i_flush > i_stall > normal fetch/load.
- Stall in RUN holds o_instr, o_valid, o_branch, o_target_offset, o_fault unchanged; a stalled HALT_WORD does not trigger HALT until it is released.

## Timing
- Fetch latency 1 cycle: i_pc sampled at edge N, o_instr valid after edge N.
- Load throughput 1 word/cycle; first fetch allowed the cycle after RUN is entered.
- Flush: output after the flush edge is NOP, o_valid 0, o_branch 0; flush during stall still applies.
- Flush on the same edge as HALT_WORD fetch suppresses it (no HALT).

## Configuration
- IMEM_JUMP_PREDECODE_EN defined: adds outputs o_jump (1, opcode 000010 J or 000011 JAL) and o_jump_target (32, {pc_plus4[31:28], instr[25:0], 2'b00}), registered with o_instr, cleared on NOP/flush/reset.
- Undefined: ports absent, J/JAL flagged as neither branch nor jump.

## Structure
- Package imem_pkg: opcode constants OP_BEQ, OP_BNE, OP_J, OP_JAL, NOP_WORD (0), state encoding LOAD/RUN/HALT.
- Sub-module imem_predecode: combinational opcode decode and sign extension, instantiated once on the memory read data.

## Test plan
- Reset, load 3 words 0x0042_9820, 0x8E64_0014, 0xFFFF_FFFF with i_load_last on third -> o_load_count 3, o_state RUN next cycle.
- Fetch i_pc 0,4,8 -> o_instr 0x0042_9820, 0x8E64_0014, 0xFFFF_FFFF one cycle later, then o_state HALT and o_valid 0.
- Word 0x1092_FFFC at address 0x10 -> o_branch 1, o_target_offset 0xFFFF_FFFC; word 0x1092_0006 -> 0x0000_0006.
- Stall 3 cycles while i_pc changes -> outputs frozen; flush asserted with stall -> NOP, o_valid 0 next cycle.
- i_pc 0x802 and 0x2 -> o_fault 1, o_instr 0; i_reload in RUN -> LOAD, o_load_count 0; writing MEM_DEPTH words without i_load_last -> RUN entered automatically.
- With IMEM_JUMP_PREDECODE_EN: 0x0800_0010 at pc 0x4 -> o_jump 1, o_jump_target 0x0000_0040.
